// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter, bit timing from a baud level.
// Optional parity stage compiled in with macro UART_TX_PARITY_EN.
//
// Ports:
//   sysclk     - system clock, all state on its rising edge
//   rst        - synchronous active-high reset
//   bclk       - baud clock level; each rising edge is one bit period
//   DBUS       - parallel word to send (DATA_W bits)
//   txd_startH - transmit request, level-sampled, honoured only when idle
//   txd        - serial line, idle high, registered
//   busy       - high from accept through the done pulse cycle
//   txd_doneH  - one-cycle pulse when the last stop period ends
//
// Parameters:
//   DATA_W     - data bits per frame, 5..9
//   STOP_BITS  - stop bits per frame, 1 or 2
//   PARITY_ODD - 0 even / 1 odd parity (only with UART_TX_PARITY_EN)

module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              bclk,
    input  logic [DATA_W-1:0] DBUS,
    input  logic              txd_startH,
    output logic              txd,
    output logic              busy,
    output logic              txd_doneH
);

    localparam int CW = $clog2(DATA_W + 1);

    if (DATA_W < 5 || DATA_W > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_param: illegal parameter set");
    end

    // START is kept as a named encoding; the start bit itself is
    // launched from SYNCH so the line falls on the first usable edge.
    typedef enum logic [2:0] {
        IDLE,
        SYNCH,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t            state_q;
    state_t            state_n;
    logic              bclk_d;
    logic              bclk_rise;
    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] sreg_n;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_n;
    logic              txd_n;
    logic              busy_n;
    logic              done_n;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
    logic              par_n;
`endif

    assign bclk_rise = bclk & ~bclk_d;

    always_comb begin
        state_n = state_q;
        sreg_n  = sreg_q;
        cnt_n   = cnt_q;
        txd_n   = txd;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        // busy stays up through the done cycle, so a request
        // seen there is dropped and the next cycle accepts.
        if (txd_doneH) begin
            busy_n = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                txd_n = 1'b1;
                if (txd_startH && !busy) begin
                    sreg_n  = DBUS;
                    busy_n  = 1'b1;
                    state_n = SYNCH;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^DBUS) ^ (PARITY_ODD != 0);
`endif
                end
            end

            SYNCH: begin
                if (bclk_rise) begin
                    txd_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = DATA;
                end
            end

            DATA: begin
                if (bclk_rise) begin
                    txd_n  = sreg_q[0];
                    sreg_n = sreg_q >> 1;
                    cnt_n  = cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        cnt_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PAR;
`else
                        state_n = STOP;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PAR: begin
                if (bclk_rise) begin
                    txd_n   = par_q;
                    state_n = STOP;
                end
            end
`endif

            // cnt counts stop periods already started; the edge
            // that finds all of them started closes the frame.
            STOP: begin
                if (bclk_rise) begin
                    if (cnt_q == CW'(STOP_BITS)) begin
                        done_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        txd_n = 1'b1;
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                txd_n   = 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= IDLE;
            bclk_d    <= 1'b0;
            sreg_q    <= '0;
            cnt_q     <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            txd_doneH <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            bclk_d    <= bclk;
            sreg_q    <= sreg_n;
            cnt_q     <= cnt_n;
            txd       <= txd_n;
            busy      <= busy_n;
            txd_doneH <= done_n;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for two uart_tx_param builds
// (8 data/1 stop/even and 5 data/2 stop/odd) on a shared 8-cycle baud.

module tb_uart_tx_param;

    typedef struct {
        int          start_cyc;
        int          len;
        logic [15:0] bits;
    } exp_t;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       sysclk = 1'b0;
    logic       rst;
    logic       rst_q = 1'b1;
    logic       bclk;
    logic [7:0] dbus8;
    logic [4:0] dbus5;
    logic       st8;
    logic       st5;
    logic       txd8, busy8, done8;
    logic       txd5, busy5, done5;

    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    exp_t q8[$];
    exp_t q5[$];
    bit   act[2];
    int   idx[2];
    exp_t cur[2];

    uart_tx_param #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) u8 (
        .sysclk(sysclk), .rst(rst), .bclk(bclk), .DBUS(dbus8),
        .txd_startH(st8), .txd(txd8), .busy(busy8), .txd_doneH(done8)
    );

    uart_tx_param #(.DATA_W(5), .STOP_BITS(2), .PARITY_ODD(1)) u5 (
        .sysclk(sysclk), .rst(rst), .bclk(bclk), .DBUS(dbus5),
        .txd_startH(st5), .txd(txd5), .busy(busy5), .txd_doneH(done5)
    );

    always #5 sysclk = ~sysclk;

    // cyc = index of the most recent rising edge
    always @(posedge sysclk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // baud level: high on edges where cyc%8 is 4..7, so rises at cyc%8==4
    initial begin
        bclk = 1'b0;
        forever begin
            @(negedge sysclk);
            bclk = ((cyc + 1) % 8) >= 4;
        end
    end

    task automatic chk(input string nm, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act_v, exp_v);
        end
    endtask

    function automatic int next_rise(input int a);
        int n;
        n = a + 1;
        while (n % 8 != 4) n++;
        return n;
    endfunction

    function automatic exp_t make_exp(input int ch, input int a,
                                      input logic [8:0] data);
        exp_t e;
        int dw, sb, odd, ones;
        dw   = (ch == 0) ? 8 : 5;
        sb   = (ch == 0) ? 1 : 2;
        odd  = (ch == 0) ? 0 : 1;
        ones = 0;
        e.start_cyc = next_rise(a);
        e.len       = 1 + dw + PB + sb;
        e.bits      = '1;
        e.bits[0]   = 1'b0;
        for (int k = 0; k < dw; k++) begin
            e.bits[1+k] = data[k];
            ones += int'(data[k]);
        end
        if (PB == 1) e.bits[1+dw] = ((ones % 2) == 1) ^ (odd == 1);
        return e;
    endfunction

    task automatic mon(input int ch, input logic t, input logic b,
                       input logic d);
        exp_t e;
        int   i;
        int   len;
        if (rst_q) begin
            act[ch] = 1'b0;
            return;
        end
        if (!act[ch]) begin
            chk($sformatf("ch%0d_idle_done", ch), int'(d), 0);
            if (t == 1'b0) begin
                if ((ch == 0 && q8.size() == 0) ||
                    (ch == 1 && q5.size() == 0)) begin
                    chk($sformatf("ch%0d_unexpected_start", ch), int'(t), 1);
                end else begin
                    if (ch == 0) e = q8.pop_front();
                    else         e = q5.pop_front();
                    chk($sformatf("ch%0d_start_cyc", ch), cyc, e.start_cyc);
                    cur[ch] = e;
                    act[ch] = 1'b1;
                    idx[ch] = 0;
                end
            end
        end else begin
            idx[ch]++;
            i   = idx[ch];
            len = cur[ch].len;
            if (i < 8 * len) begin
                chk($sformatf("ch%0d_done_early", ch), int'(d), 0);
                if (i % 8 == 4) begin
                    chk($sformatf("ch%0d_bit%0d", ch, i / 8), int'(t),
                        int'(cur[ch].bits[i/8]));
                    chk($sformatf("ch%0d_busy_frame", ch), int'(b), 1);
                end
            end else if (i == 8 * len) begin
                chk($sformatf("ch%0d_done_pulse", ch), int'(d), 1);
                chk($sformatf("ch%0d_busy_at_done", ch), int'(b), 1);
            end else begin
                chk($sformatf("ch%0d_done_width", ch), int'(d), 0);
                chk($sformatf("ch%0d_busy_after", ch), int'(b), 0);
                act[ch] = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge sysclk);
            mon(0, txd8, busy8, done8);
            mon(1, txd5, busy5, done5);
        end
    end

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send(input int ch, input logic [8:0] data,
                        output int done_cyc);
        exp_t e;
        int   a;
        a = cyc + 1;
        e = make_exp(ch, a, data);
        if (ch == 0) begin
            dbus8 = data[7:0];
            st8   = 1'b1;
            q8.push_back(e);
        end else begin
            dbus5 = data[4:0];
            st5   = 1'b1;
            q5.push_back(e);
        end
        tick();
        st8 = 1'b0;
        st5 = 1'b0;
        done_cyc = e.start_cyc + 8 * e.len;
    endtask

    initial begin
        int   dc, d1, d2, a2, s;
        exp_t e1, e2;
        rst   = 1'b1;
        st8   = 1'b0;
        st5   = 1'b0;
        dbus8 = '0;
        dbus5 = '0;
        repeat (3) tick();
        chk("rst_txd8", int'(txd8), 1);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_txd5", int'(txd5), 1);
        chk("rst_busy5", int'(busy5), 0);
        chk("rst_done5", int'(done5), 0);

        // request in the first cycle out of reset
        rst = 1'b0;
        send(0, 9'h0A5, dc);
        wait_until(dc + 1);

        send(1, 9'h01F, dc);
        wait_until(dc + 1);

        send(0, 9'h007, dc);
        wait_until(dc + 1);
        send(1, 9'h007, dc);
        wait_until(dc + 1);

        // accept on the same edge as a baud rise
        while ((cyc + 1) % 8 != 4) tick();
        send(0, 9'h05A, dc);
        wait_until(dc + 1);
        while ((cyc + 1) % 8 != 4) tick();
        send(1, 9'h00A, dc);
        wait_until(dc + 1);

        // request held high, word changed mid-frame
        repeat (3) tick();
        dbus8 = 8'h3C;
        st8   = 1'b1;
        e1    = make_exp(0, cyc + 1, 9'h03C);
        q8.push_back(e1);
        d1    = e1.start_cyc + 8 * e1.len;
        repeat (40) tick();
        dbus8 = 8'hC1;
        a2    = d1 + 2;
        e2    = make_exp(0, a2, 9'h0C1);
        q8.push_back(e2);
        d2    = e2.start_cyc + 8 * e2.len;
        wait_until(a2);
        st8 = 1'b0;
        wait_until(d2 + 1);

        // reset in the middle of data bit 3
        send(0, 9'h0E7, dc);
        s = dc - 8 * (1 + 8 + PB + 1);
        wait_until(s + 34);
        rst = 1'b1;
        tick();
        chk("abort_txd", int'(txd8), 1);
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        rst = 1'b0;
        repeat (20) tick();
        send(0, 9'h09B, dc);
        wait_until(dc + 1);

        for (int r = 0; r < 12; r++) begin
            int ch;
            int gap;
            logic [8:0] d;
            ch  = int'($urandom_range(1, 0));
            d   = 9'($urandom);
            gap = int'($urandom_range(9, 0));
            repeat (gap) tick();
            send(ch, d, dc);
            wait_until(dc + 1);
        end

        repeat (30) tick();
        chk("q8_left", q8.size(), 0);
        chk("q5_left", q5.size(), 0);
        chk("mon_active", int'(act[0]) + int'(act[1]), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
